regfile_wb_scheduler: RTL and testbench
=======================================

// Module: regfile_wb_scheduler
// PURPOSE
//  Shares the register file's single write port among NREQ write-back requesters (ALU, load unit,
//  mul/div) using a round-robin arbiter with valid/ready handshakes. Drives write_en/write_addr/
//  write_data of the 32x32 register file through a one-cycle registered stage.
//  Also keeps a 32-bit pending-write scoreboard. Issue logic uses it to stall on RAW/WAW hazards.
// PARAMETERS
//  NREQ       3   number of write-back requesters (2..8)
//  XLEN       32  data width
//  AW         5   register address width
// PORTS
//  clk            in   1          clock; all state updates on rising edge
//  rst_n          in   1          asynchronous, active-low reset
//  req_valid      in   NREQ       requester i has a result
//  req_ready      out  NREQ       requester i granted this cycle (combinational, one-hot or zero)
//  req_addr       in   NREQ*AW    rd of requester i, slice [i*AW +: AW]
//  req_data       in   NREQ*XLEN  result of requester i, slice [i*XLEN +: XLEN]
//  write_en       out  1          to register file write port
//  write_addr     out  AW         to register file write port
//  write_data     out  XLEN       to register file write port
//  issue_valid    in   1          decode issues an instruction that writes issue_rd
//  issue_rd       in   AW         destination of issued instruction
//  rs1_addr       in   AW         scoreboard query port 1
//  rs2_addr       in   AW         scoreboard query port 2
//  rs1_busy       out  1          rs1_addr has a pending write
//  rs2_busy       out  1          rs2_addr has a pending write
//  rd_busy        out  1          issue_rd has a pending write (WAW stall)
// BEHAVIOUR
//  - Reset (async, rst_n=0): write_en=0, write_addr=0, write_data=0, busy[31:0]=0, rr_ptr=0.
//    req_ready is 0 while in reset. Reset mid-transfer drops any in-flight write.
//  - Arbitration: grant the first requester with valid=1, searching from rr_ptr upward with
//    wrap-around. req_ready[g]=1 for that requester only. Handshake = valid & ready.
//  - rr_ptr <= (g+1) mod NREQ on a grant; otherwise it holds. A requester is served within NREQ cycles.
//  - The scheduler never back-pressures: if any requester is valid, exactly one is granted.
//  - Requesters hold valid/addr/data stable until ready. Ready may depend on valid, not vice versa.
//  - Write stage: on handshake, next cycle write_en=(addr!=0), write_addr=addr, write_data=data.
//    With no handshake, write_en=0 and addr/data hold. Latency is 1 cycle, one write per cycle max.
//  - A handshake with addr=0 is consumed (ready=1) and produces no write.
//  - Scoreboard: issue_valid & issue_rd!=0 sets busy[issue_rd]. A handshake on addr clears busy[addr].
//  - Same-cycle set and clear of the same register: set wins (a new writer is pending).
//  - Busy flags read the registered busy bits: rs*_busy=busy[rs*_addr], rd_busy=busy[issue_rd].
//  - Address 0 always reads not-busy.
//  - Queries return busy=1 until the clearing handshake's edge. Bypassing is the pipeline's job.
//  - Issue to an rd that is already busy is illegal. Decode must stall on rd_busy.
//    A bench assertion flags issue_valid & rd_busy & issue_rd!=0.
//  - Handshake on an rd whose busy=0 is legal: the write still happens and busy stays 0.
// STRUCTURE
//  - Shared package cpu_pkg: XLEN, REG_AW, NUM_WB_PORTS, and WB port index constants
//    WB_ALU=0, WB_LSU=1, WB_MDU=2.
//  - Sub-module rr_arbiter #(N): req[N-1:0] -> one-hot gnt[N-1:0] plus registered pointer.
//    Top level holds the write stage, the scoreboard and the operand mux.
// TESTING
//  - Reset: assert rst_n=0 mid-burst -> write_en=0, write_addr=0, all busy=0, req_ready=0 immediately.
//  - Single request: ALU valid addr=5 data=0xDEADBEEF -> ready same cycle.
//    Next cycle write_en=1, addr=5, data=0xDEADBEEF.
//  - Fairness: all 3 valid continuously, rr_ptr=0 -> grants 0,1,2,0,1,2.
//    write stream follows one cycle later with no bubbles.
//  - x0 drop: LSU valid addr=0 data=0x1234 -> ready=1, next cycle write_en=0, busy unchanged.
//  - Scoreboard: issue rd=7 -> rs1_busy=1 for rs1=7 next cycle. MDU handshake addr=7 -> busy clears next edge.
//    Same-cycle issue rd=7 and handshake addr=7 -> busy stays 1.
//  - Back-to-back: issue rd=3, then rd=4, then writes 4 then 3 -> both clear; rd_busy tracks each correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants for the write-back path: datapath widths,
// number of write-back ports and the fixed index of each requester.
package cpu_pkg;

  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int NUM_REGS     = 1 << REG_AW;
  localparam int NUM_WB_PORTS = 3;

  // Fixed requester slots on the write-back arbiter
  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward with wrap-around,
// grants the first active request, and moves the pointer just past the winner.
module rr_arbiter
  import cpu_pkg::*;
#(
  parameter int N = NUM_WB_PORTS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          found;

  // Pick the first requester at or after the pointer position
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found                       = 1'b1;
        gnt[(int'(ptr) + k) % N]    = 1'b1;
        gnt_idx                     = PW'((int'(ptr) + k) % N);
      end
    end
  end

  // Advance the pointer past the winner; hold it when nobody asks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: shares the register file write port among the
// write-back units via a round-robin arbiter, registers the selected write
// for one cycle, and tracks outstanding destinations in a busy scoreboard.
module regfile_wb_scheduler
  import cpu_pkg::*;
#(
  parameter int NREQ = cpu_pkg::NUM_WB_PORTS,
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int AW   = cpu_pkg::REG_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 write_en,
  output logic [AW-1:0]        write_addr,
  output logic [XLEN-1:0]      write_data,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [AW-1:0]        rs1_addr,
  input  logic [AW-1:0]        rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy
);

  localparam int NREG = 1 << AW;

  logic [NREQ-1:0] gnt;
  logic            hs;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .gnt   (gnt)
  );

  // No grant may be visible while reset is held, even with valid inputs
  always_comb begin
    req_ready = gnt & {NREQ{rst_n}};
    hs        = |req_ready;
  end

  // Route the granted requester's destination and result to the write stage
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // One-cycle registered write port; x0 handshakes are consumed silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
    end else if (hs) begin
      write_en   <= (sel_addr != '0);
      write_addr <= sel_addr;
      write_data <= sel_data;
    end else begin
      write_en   <= 1'b0;
    end
  end

  // Clear on write-back, set on issue; a same-cycle issue wins because it is a newer writer
  always_comb begin
    busy_next = busy;
    if (hs) begin
      busy_next[sel_addr] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Registered pending-write scoreboard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // Queries see only the registered bits; x0 is never busy
  always_comb begin
    rs1_busy = (rs1_addr != '0) && busy[rs1_addr];
    rs2_busy = (rs2_addr != '0) && busy[rs2_addr];
    rd_busy  = (issue_rd != '0) && busy[issue_rd];
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: stimulus pushes expected register
// file writes into a queue, a negedge monitor pops them as writes appear.
module tb_regfile_wb_scheduler;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_busy;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expq[$];
  wr_t         monE;
  logic [4:0]  tbAddr[3];
  logic [31:0] tbData[3];
  int          checks = 0;
  int          fails  = 0;

  regfile_wb_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rd_busy     (rd_busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a stuck run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [4:0] a0, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2);
    tbAddr[0] = a0; tbAddr[1] = a1; tbAddr[2] = a2;
    tbData[0] = d0; tbData[1] = d1; tbData[2] = d2;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  task automatic setQuery(input logic iv, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    issue_valid = iv;
    issue_rd    = rd;
    rs1_addr    = r1;
    rs2_addr    = r2;
  endtask

  // Check the combinational grant and queue the write the grant must produce
  task automatic expectGrant(input string name, input logic [2:0] exp);
    wr_t e;
    #1;
    checkOutput(name, {29'd0, req_ready}, {29'd0, exp});
    for (int i = 0; i < 3; i++) begin
      if (exp[i] && tbAddr[i] != 5'd0) begin
        e.addr = tbAddr[i];
        e.data = tbData[i];
        expq.push_back(e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every register file write must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && write_en !== 1'b0) begin
      if (expq.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_write actual addr=%0d data=%h required=no write", write_addr, write_data);
      end else begin
        monE = expq.pop_front();
        checkOutput("mon_write_addr", {27'd0, write_addr}, {27'd0, monE.addr});
        checkOutput("mon_write_data", write_data, monE.data);
      end
    end
  end

  // Decode must never issue to a destination that is still pending
  always @(negedge clk) begin
    if (rst_n === 1'b1 && issue_valid && rd_busy && issue_rd != 5'd0) begin
      checks++;
      fails++;
      $display("[TB] FAIL waw_issue actual=issue to busy rd %0d required=stall", issue_rd);
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    setQuery(1'b0, 0, 0, 0);
    step();
    step();
    checkOutput("reset_write_en", {31'd0, write_en}, 0);
    checkOutput("reset_write_addr", {27'd0, write_addr}, 0);
    checkOutput("reset_write_data", write_data, 0);
    applyStimulus(3'b111, 1, 2, 3, 32'h1, 32'h2, 32'h3);
    expectGrant("reset_ready", 3'b000);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    // Single ALU request
    applyStimulus(3'b001, 5, 0, 0, 32'hDEADBEEF, 0, 0);
    expectGrant("single_ready", 3'b001);
    step();
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    checkOutput("single_write_en", {31'd0, write_en}, 1);
    step();
    checkOutput("idle_write_en", {31'd0, write_en}, 0);
    checkOutput("idle_addr_hold", {27'd0, write_addr}, 5);
    checkOutput("idle_data_hold", write_data, 32'hDEADBEEF);

    // x0 write is consumed without a register file write
    applyStimulus(3'b010, 0, 0, 0, 0, 32'h1234, 0);
    expectGrant("x0_ready", 3'b010);
    step();
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_write_en", {31'd0, write_en}, 0);
    #1;
    checkOutput("x0_rs1_busy", {31'd0, rs1_busy}, 0);

    // Scoreboard set and clear on rd=7
    setQuery(1'b1, 7, 7, 0);
    #1;
    checkOutput("sb_rd_busy_pre", {31'd0, rd_busy}, 0);
    step();
    setQuery(1'b0, 7, 7, 0);
    #1;
    checkOutput("sb_rs1_busy_set", {31'd0, rs1_busy}, 1);
    checkOutput("sb_rd_busy_set", {31'd0, rd_busy}, 1);
    applyStimulus(3'b100, 0, 0, 7, 0, 0, 32'h77);
    expectGrant("sb_mdu_ready", 3'b100);
    checkOutput("sb_busy_before_edge", {31'd0, rs1_busy}, 1);
    step();
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("sb_busy_cleared", {31'd0, rs1_busy}, 0);

    // Same-cycle issue and write-back of rd=7: the new issue keeps it busy
    setQuery(1'b1, 7, 7, 0);
    applyStimulus(3'b100, 0, 0, 7, 0, 0, 32'h88);
    expectGrant("same_ready", 3'b100);
    step();
    setQuery(1'b0, 7, 7, 0);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("same_busy_stays", {31'd0, rs1_busy}, 1);
    applyStimulus(3'b001, 7, 0, 0, 32'h99, 0, 0);
    expectGrant("clr7_ready", 3'b001);
    step();
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("clr7_busy", {31'd0, rs1_busy}, 0);

    // Back-to-back issues to 3 and 4, retired in reverse order
    setQuery(1'b1, 3, 3, 4);
    #1;
    checkOutput("b2b_rd3_pre", {31'd0, rd_busy}, 0);
    step();
    setQuery(1'b1, 4, 3, 4);
    #1;
    checkOutput("b2b_rd4_pre", {31'd0, rd_busy}, 0);
    checkOutput("b2b_rs1_3_busy", {31'd0, rs1_busy}, 1);
    step();
    setQuery(1'b0, 4, 3, 4);
    #1;
    checkOutput("b2b_both_rs1", {31'd0, rs1_busy}, 1);
    checkOutput("b2b_both_rs2", {31'd0, rs2_busy}, 1);
    checkOutput("b2b_rd4_busy", {31'd0, rd_busy}, 1);
    applyStimulus(3'b010, 0, 4, 0, 0, 32'h4444, 0);
    expectGrant("b2b_w4_ready", 3'b010);
    step();
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("b2b_w4_rs2", {31'd0, rs2_busy}, 0);
    checkOutput("b2b_w4_rs1", {31'd0, rs1_busy}, 1);
    checkOutput("b2b_w4_rd", {31'd0, rd_busy}, 0);
    applyStimulus(3'b001, 3, 0, 0, 32'h3333, 0, 0);
    expectGrant("b2b_w3_ready", 3'b001);
    step();
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    setQuery(1'b0, 3, 3, 4);
    #1;
    checkOutput("b2b_w3_rs1", {31'd0, rs1_busy}, 0);
    checkOutput("b2b_w3_rd", {31'd0, rd_busy}, 0);

    // Reset in the middle of a burst drops the in-flight write and the scoreboard
    setQuery(1'b1, 9, 9, 0);
    step();
    setQuery(1'b0, 9, 9, 0);
    #1;
    checkOutput("pre_reset_busy", {31'd0, rs1_busy}, 1);
    applyStimulus(3'b111, 1, 2, 3, 32'h11, 32'h22, 32'h33);
    expectGrant("burst_ready", 3'b010);
    step();
    rst_n = 1'b0;
    expq.delete();
    #1;
    checkOutput("midrst_write_en", {31'd0, write_en}, 0);
    checkOutput("midrst_write_addr", {27'd0, write_addr}, 0);
    checkOutput("midrst_write_data", write_data, 0);
    checkOutput("midrst_ready", {29'd0, req_ready}, 0);
    checkOutput("midrst_busy", {31'd0, rs1_busy}, 0);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    setQuery(1'b0, 0, 0, 0);

    // Fairness: all three valid from pointer 0, writes follow with no bubbles
    applyStimulus(3'b111, 10, 11, 12, 32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2);
    for (int c = 0; c < 6; c++) begin
      logic [2:0] e;
      e = 3'b001 << (c % 3);
      expectGrant($sformatf("fair_ready_%0d", c), e);
      if (c > 0) begin
        checkOutput($sformatf("fair_no_bubble_%0d", c), {31'd0, write_en}, 1);
      end
      step();
    end
    checkOutput("fair_last_write", {31'd0, write_en}, 1);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0);
    step();
    checkOutput("fair_idle_write_en", {31'd0, write_en}, 0);
    step();
    step();
    checkOutput("queue_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
